// File: rtl/mem_ctrl_pkg.sv
// Shared types for the L3 main-memory controller: FSM states, op codes, line geometry.
// Latency/backpressure: not applicable, types only.
package mem_ctrl_pkg;

    localparam int DEF_LINE_SIZE = 16;
    localparam int OFFSET_W      = $clog2(DEF_LINE_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACCESS,
        READ_DATA,
        RESP,
        RECOVER
    } mc_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } mc_op_t;

endpackage

// File: rtl/mc_latency_counter.sv
// Loadable down-counter with zero flag; times the wait before each RAM access.
// Load takes effect next cycle; decrement saturates at zero, no backpressure.
module mc_latency_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mc_sim_ram.sv
// Behavioural single-port RAM: 1-cycle registered read, write on en && we.
// Read data appears the cycle after a read strobe; always ready.
module mc_sim_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/l3_mem_controller.sv
// Main-memory controller behind the L3: one word per request/ready handshake.
// Latency FIRST_LATENCY+3 (read) / +2 (write), BURST_LATENCY for same-line sequential words.
module l3_mem_controller
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 16,
    parameter int LINE_SIZE      = DEF_LINE_SIZE,
    parameter int FIRST_LATENCY  = 8,
    parameter int BURST_LATENCY  = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [DATA_WIDTH-1:0]     mem_address,
    input  logic [DATA_WIDTH-1:0]     mem_write_data,
    output logic [DATA_WIDTH-1:0]     mem_read_data,
    output logic                      mem_ready,
    output logic                      ram_en,
    output logic                      ram_we,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]     ram_wdata,
    input  logic [DATA_WIDTH-1:0]     ram_rdata
);

    localparam int OFF_W = $clog2(LINE_SIZE);
    localparam int CNT_W = $clog2(FIRST_LATENCY + 1);

    mc_state_t                 state;
    mc_op_t                    op_q;
    mc_op_t                    last_op;
    logic [RAM_ADDR_WIDTH-1:0] addr_q;
    logic [RAM_ADDR_WIDTH-1:0] last_addr;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic                      last_addr_valid;

    logic                      req;
    mc_op_t                    req_op;
    logic [RAM_ADDR_WIDTH-1:0] word_addr;
    logic [RAM_ADDR_WIDTH:0]   next_addr;
    logic                      seq;
    logic                      unused_addr_bits;

    logic                      cnt_load;
    logic                      cnt_dec;
    logic [CNT_W-1:0]          cnt_load_val;
    logic [CNT_W-1:0]          cnt_value;
    logic                      cnt_zero;

    assign req       = mem_read | mem_write;
    assign req_op    = mem_write ? OP_WRITE : OP_READ;
    assign word_addr = mem_address[RAM_ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{mem_address[DATA_WIDTH-1:RAM_ADDR_WIDTH+2], mem_address[1:0], cnt_value};

    // The extra carry bit keeps 0xFFFF+1 from aliasing onto word 0.
    assign next_addr = {1'b0, last_addr} + {{RAM_ADDR_WIDTH{1'b0}}, 1'b1};
    assign seq = last_addr_valid
              && (next_addr == {1'b0, word_addr})
              && (word_addr[RAM_ADDR_WIDTH-1:OFF_W] == last_addr[RAM_ADDR_WIDTH-1:OFF_W])
              && (req_op == last_op);

    assign cnt_load     = (state == IDLE) && req;
    assign cnt_dec      = (state == WAIT);
    assign cnt_load_val = seq ? CNT_W'(BURST_LATENCY - 1) : CNT_W'(FIRST_LATENCY - 1);

    mc_latency_counter #(
        .WIDTH(CNT_W)
    ) u_latency_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt_value),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            op_q            <= OP_READ;
            last_op         <= OP_READ;
            addr_q          <= '0;
            last_addr       <= '0;
            wdata_q         <= '0;
            last_addr_valid <= 1'b0;
            mem_ready       <= 1'b0;
            mem_read_data   <= '0;
            ram_en          <= 1'b0;
            ram_we          <= 1'b0;
            ram_addr        <= '0;
            ram_wdata       <= '0;
        end else begin
            mem_ready <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q  <= word_addr;
                        wdata_q <= mem_write_data;
                        op_q    <= req_op;
                        state   <= WAIT;
                    end else begin
                        last_addr_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    // Strobe is registered so it lines up with the ACCESS state.
                    if (cnt_zero) begin
                        ram_en    <= 1'b1;
                        ram_we    <= (op_q == OP_WRITE);
                        ram_addr  <= addr_q;
                        ram_wdata <= wdata_q;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (op_q == OP_WRITE) begin
                        mem_ready <= 1'b1;
                        state     <= RESP;
                    end else begin
                        state <= READ_DATA;
                    end
                end
                READ_DATA: begin
                    mem_read_data <= ram_rdata;
                    mem_ready     <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    last_addr       <= addr_q;
                    last_op         <= op_q;
                    last_addr_valid <= 1'b1;
                    state           <= RECOVER;
                end
                RECOVER: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l3_mem_controller.sv
// Scoreboard bench for l3_mem_controller: driver pushes expected word/cycle, monitor checks on mem_ready.
`timescale 1ns/1ps
module tb_l3_mem_controller;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int FL = 8;
    localparam int BL = 2;
    localparam int RD_FIRST = FL + 3;
    localparam int RD_BURST = BL + 3;
    localparam int WR_FIRST = FL + 2;
    localparam int WR_BURST = BL + 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    logic [DW-1:0] mem_address = '0;
    logic [DW-1:0] mem_write_data = '0;
    logic [DW-1:0] mem_read_data;
    logic          mem_ready;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    always #5 clk = ~clk;

    l3_mem_controller #(
        .DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW), .LINE_SIZE(16),
        .FIRST_LATENCY(FL), .BURST_LATENCY(BL)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .mem_ready      (mem_ready),
        .ram_en         (ram_en),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata)
    );

    mc_sim_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            exp_cyc;
        string         name;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            wr_count = 0;
    int            last_ready = 0;
    int            wr_before;
    logic [DW-1:0] model_rd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every mem_ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && mem_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready cyc=%0d got data=%h want no pulse", cyc, mem_read_data);
            end else begin
                mon_e = sb.pop_front();
                if (cyc != mon_e.exp_cyc) begin
                    errors++;
                    $display("FAIL %s_latency got cyc=%0d want cyc=%0d", mon_e.name, cyc, mon_e.exp_cyc);
                end
                checks++;
                if (mem_read_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL %s_data got=%h want=%h", mon_e.name, mem_read_data, mon_e.data);
                end
            end
        end
        if (reset_n && ram_en && ram_we) wr_count++;
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (mem_ready) got = 1'b1;
        end
        if (got) begin
            last_ready = cyc;
        end else begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got no mem_ready want pulse within 60 cycles", name);
            sb.delete();
        end
    endtask

    // Called at a negedge. A chained word is sampled two cycles after the previous
    // ready (RESP -> RECOVER -> IDLE); a fresh one in the current cycle.
    task automatic access(input bit wr, input bit both, input logic [DW-1:0] addr,
                          input logic [DW-1:0] data, input int lat, input bit chained,
                          input string name);
        exp_t e;
        mem_address    = addr;
        mem_write_data = data;
        mem_write      = wr;
        mem_read       = !wr || both;
        if (!wr) model_rd = data;
        e.data    = model_rd;
        e.exp_cyc = (chained ? last_ready + 2 : cyc) + lat;
        e.name    = name;
        sb.push_back(e);
        wait_ready(name);
    endtask

    task automatic gap();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [DW-1:0] fill_val(input int i);
        return 32'hF1110000 + DW'(i);
    endfunction

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_mem_ready"}, {31'd0, mem_ready}, 32'd0);
        chk({tag, "_mem_read_data"}, mem_read_data, 32'd0);
        chk({tag, "_ram_en"}, {31'd0, ram_en}, 32'd0);
        chk({tag, "_ram_we"}, {31'd0, ram_we}, 32'd0);
        chk({tag, "_ram_addr"}, {16'd0, ram_addr}, 32'd0);
        chk({tag, "_ram_wdata"}, ram_wdata, 32'd0);
    endtask

    initial begin
        u_ram.mem[16'h0002] <= 32'h0BADF00D;
        u_ram.mem[16'h0040] <= 32'hDEADBEEF;
        u_ram.mem[16'h0041] <= 32'h41414141;
        u_ram.mem[16'h0410] <= 32'h10401040;
        for (int i = 0; i < 16; i++) begin
            u_ram.mem[16'h0400 + 16'(i)] <= fill_val(i);
            u_ram.mem[16'h0800 + 16'(i)] <= 32'hFFFFFFFF;
        end

        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        access(1'b0, 1'b0, 32'h100, 32'hDEADBEEF, RD_FIRST, 1'b0, "single_read");
        gap();

        for (int i = 0; i < 16; i++) begin
            access(1'b0, 1'b0, 32'h1000 + DW'(4 * i), fill_val(i),
                   (i == 0) ? RD_FIRST : RD_BURST, i != 0, $sformatf("fill%0d", i));
        end
        gap();

        wr_before = wr_count;
        for (int i = 0; i < 16; i++) begin
            access(1'b1, 1'b0, 32'h2000 + DW'(4 * i), DW'(i * 3),
                   (i == 0) ? WR_FIRST : WR_BURST, i != 0, $sformatf("wb%0d", i));
        end
        gap();
        chk("wb_write_count", DW'(wr_count - wr_before), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("wb_ram%0d", i), u_ram.mem[16'h0800 + 16'(i)], DW'(i * 3));
        end

        // 0x103C is the last word of its line, so 0x1040 must pay the full latency.
        access(1'b0, 1'b0, 32'h1038, fill_val(14), RD_FIRST, 1'b0, "wrap_a");
        access(1'b0, 1'b0, 32'h103C, fill_val(15), RD_BURST, 1'b1, "wrap_b");
        access(1'b0, 1'b0, 32'h1040, 32'h10401040, RD_FIRST, 1'b1, "wrap_c");
        gap();

        wr_before = wr_count;
        access(1'b1, 1'b1, 32'h8, 32'h5A5A1234, WR_FIRST, 1'b0, "both_high");
        gap();
        chk("both_high_ram", u_ram.mem[16'h0002], 32'h5A5A1234);
        chk("both_high_write_count", DW'(wr_count - wr_before), 32'd1);

        access(1'b0, 1'b0, 32'h100, 32'hDEADBEEF, RD_FIRST, 1'b0, "pre_reset_read");
        mem_address = 32'h104;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_outputs_zero("abort");
        model_rd = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        access(1'b0, 1'b0, 32'h104, 32'h41414141, RD_FIRST, 1'b0, "post_reset_read");
        gap();
        repeat (5) @(negedge clk);

        chk("scoreboard_drained", DW'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
